// File: rtl/chu_vga_card_flip_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : chu_vga_card_flip_core
// Purpose  : Card-overlay video core. A COLS x ROWS tile map of card codes is
//            rendered through an external glyph ROM and blended onto the
//            pixel stream (key / bypass / 50% alpha). A flip engine wipes one
//            face-down card to face-up, one tile line per FRAMES_PER_STEP
//            frames, then clears its hidden bit.
// Revision : 1.0 - initial release
// ============================================================================
module chu_vga_card_flip_core #(
    parameter int CD              = 12,
    parameter int COLS            = 32,
    parameter int ROWS            = 8,
    parameter int CODE_W          = 6,
    parameter int TILE_PX         = 16,
    parameter int BACK_CODE       = 63,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [10:0]                           x,
    input  logic [10:0]                           y,
    input  logic                                  cs,
    input  logic                                  write,
    input  logic [13:0]                           addr,
    input  logic [31:0]                           wr_data,
    output logic [31:0]                           rd_data,
    output logic [CODE_W+2*$clog2(TILE_PX)-1:0]   glyph_addr,
    input  logic                                  glyph_pix,
    input  logic [CD-1:0]                         si_rgb,
    output logic [CD-1:0]                         so_rgb
);

    localparam int c_tb  = $clog2(TILE_PX);
    localparam int c_cb  = $clog2(COLS);
    localparam int c_rb  = $clog2(ROWS);
    localparam int c_sw  = c_cb + c_rb;
    localparam int c_chw = CD / 3;
    localparam int c_fcw = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [c_fcw-1:0]  c_fc_last   = c_fcw'(FRAMES_PER_STEP - 1);
    localparam logic [7:0]        c_prog_done = 8'(TILE_PX);
    localparam logic [CODE_W-1:0] c_back      = CODE_W'(BACK_CODE);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_clear = 2'd2;

    // Tile map entry layout: {hidden, code}
    logic [CODE_W:0]      r_map [COLS*ROWS];

    logic [1:0]           r_state;
    logic [c_sw-1:0]      r_slot;
    logic [7:0]           r_progress;
    logic [c_fcw-1:0]     r_frame_cnt;
    logic [1:0]           r_mode;
    logic [CD-1:0]        r_fg;
    logic                 r_prev_origin;

    logic [CODE_W:0]      r_ent;
    logic [c_sw-1:0]      r_pslot;
    logic [c_tb-1:0]      r_yin;
    logic [c_tb-1:0]      r_xin;
    logic [CD-1:0]        r_si1;
    logic [CD-1:0]        r_si2;

    logic                 w_tile_wr;
    logic                 w_reg_wr;
    logic                 w_flip_start;
    logic                 w_origin;
    logic                 w_strobe;
    logic                 w_busy;
    logic                 w_eng_clear;
    logic [c_sw-1:0]      w_pix_slot;
    logic                 w_reveal;
    logic [CODE_W-1:0]    w_eff_code;
    logic [CD-1:0]        w_avg;
    logic [CD-1:0]        w_blend;
    logic                 w_unused_inputs;

    assign w_tile_wr    = cs & write & ~addr[13];
    assign w_reg_wr     = cs & write & addr[13];
    assign w_flip_start = w_reg_wr && (addr[2:0] == 3'd2);
    assign w_origin     = (x == 11'd0) && (y == 11'd0);
    assign w_strobe     = w_origin & ~r_prev_origin;
    assign w_busy       = (r_state != c_st_idle);
    // The CPU owns the single map write port; the engine waits a cycle if needed.
    assign w_eng_clear  = (r_state == c_st_clear) && !w_tile_wr;
    // Screen coordinates wrap modulo the map size by plain truncation.
    assign w_pix_slot   = {y[c_tb+c_rb-1:c_tb], x[c_tb+c_cb-1:c_tb]};
    assign rd_data      = {w_busy, 23'd0, r_progress};
    assign w_unused_inputs = ^{x, y, addr, wr_data};

    // Tile map storage: CPU writes first, engine hidden-bit clear otherwise.
    always_ff @(posedge clk) begin
        if (w_tile_wr) begin
            r_map[addr[c_sw-1:0]] <= {wr_data[8], wr_data[CODE_W-1:0]};
        end else if (w_eng_clear) begin
            r_map[r_slot][CODE_W] <= 1'b0;
        end
    end

    // Control registers written by the CPU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= 2'b00;
            r_fg   <= '1;
        end else if (w_reg_wr) begin
            case (addr[2:0])
                3'd0:    r_mode <= wr_data[1:0];
                3'd1:    r_fg   <= wr_data[CD-1:0];
                default: ;
            endcase
        end
    end

    // Frame-start detector history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_origin <= 1'b0;
        end else begin
            r_prev_origin <= w_origin;
        end
    end

    // Flip engine: latch slot, advance the wipe per frame group, clear hidden.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_slot      <= '0;
            r_progress  <= 8'd0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_flip_start) begin
                        r_slot      <= wr_data[c_sw-1:0];
                        r_progress  <= 8'd0;
                        r_frame_cnt <= '0;
                        r_state     <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (w_strobe) begin
                        if (r_frame_cnt == c_fc_last) begin
                            r_frame_cnt <= '0;
                            r_progress  <= r_progress + 8'd1;
                            if (r_progress + 8'd1 == c_prog_done) begin
                                r_state <= c_st_clear;
                            end
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end
                end
                c_st_clear: begin
                    if (w_eng_clear) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Lines above the wipe front of the flipping slot show the real face.
    assign w_reveal   = w_busy && (r_pslot == r_slot) &&
                        ({{(8-c_tb){1'b0}}, r_yin} < r_progress);
    assign w_eff_code = (r_ent[CODE_W] && !w_reveal) ? c_back : r_ent[CODE_W-1:0];

    // Pixel pipeline: map read, glyph address, blended output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ent      <= '0;
            r_pslot    <= '0;
            r_yin      <= '0;
            r_xin      <= '0;
            r_si1      <= '0;
            r_si2      <= '0;
            glyph_addr <= '0;
            so_rgb     <= '0;
        end else begin
            r_ent      <= r_map[w_pix_slot];
            r_pslot    <= w_pix_slot;
            r_yin      <= y[c_tb-1:0];
            r_xin      <= x[c_tb-1:0];
            r_si1      <= si_rgb;
            glyph_addr <= {w_eff_code, r_yin, r_xin};
            r_si2      <= r_si1;
            so_rgb     <= w_blend;
        end
    end

    // Per-channel average, one carry bit wide, truncated back to channel width.
    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [c_chw:0] w_sum;
        assign w_sum = {1'b0, r_fg[i*c_chw +: c_chw]} + {1'b0, r_si2[i*c_chw +: c_chw]};
        assign w_avg[i*c_chw +: c_chw] = w_sum[c_chw:1];
    end

    // Mode mux; mode 11 falls through to chroma-key.
    always_comb begin
        w_blend = r_si2;
        case (r_mode)
            2'b01:   w_blend = r_si2;
            2'b10:   if (glyph_pix) w_blend = w_avg;
            default: if (glyph_pix) w_blend = r_fg;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_chu_vga_card_flip_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_chu_vga_card_flip_core
// Purpose  : Self-checking bench: blend vector table, flip-engine sequences,
//            random pixel streams against a tile-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chu_vga_card_flip_core;

    localparam int TILE = 16;
    localparam int NCOL = 32;
    localparam int NROW = 8;
    localparam int FPS  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] x, y;
    logic        cs, write;
    logic [13:0] addr;
    logic [31:0] wr_data, rd_data;
    logic [13:0] glyph_addr;
    logic        glyph_pix;
    logic [11:0] si_rgb, so_rgb;

    always #5 clk = ~clk;

    chu_vga_card_flip_core dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .cs         (cs),
        .write      (write),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .glyph_addr (glyph_addr),
        .glyph_pix  (glyph_pix),
        .si_rgb     (si_rgb),
        .so_rgb     (so_rgb)
    );

    // Glyph ROM: codes 5 and 7 solid, 0..4/6 and 63 blank, others a pattern.
    function automatic bit rom_pix(input int code, input int yy, input int xx);
        if (code == 5 || code == 7) return 1'b1;
        if (code >= 8 && code != 63) return ((xx + 2*yy + code) % 3) == 0;
        return 1'b0;
    endfunction

    assign glyph_pix = rom_pix(int'(glyph_addr[13:8]), int'(glyph_addr[7:4]), int'(glyph_addr[3:0]));

    // Reference model state
    int m_code [NCOL*NROW];
    bit m_hid  [NCOL*NROW];
    int m_mode, m_fg, m_slot, m_strobes;
    bit m_busy;

    int n_vec = 0;
    int n_bad = 0;

    function automatic int m_prog();
        int p;
        p = m_strobes / FPS;
        return (p > TILE) ? TILE : p;
    endfunction

    function automatic int model_so(input int px, input int py, input int si);
        int idx, yy, xx, code, res;
        bit pix;
        idx  = ((py / TILE) % NROW) * NCOL + ((px / TILE) % NCOL);
        yy   = py % TILE;
        xx   = px % TILE;
        code = m_code[idx];
        if (m_hid[idx] && !(m_busy && idx == m_slot && yy < m_prog())) code = 63;
        pix = rom_pix(code, yy, xx);
        if (m_mode == 1 || !pix) return si;
        if (m_mode == 2) begin
            res = 0;
            for (int ch = 0; ch < 3; ch++)
                res |= (((((m_fg >> (4*ch)) & 15) + ((si >> (4*ch)) & 15)) >> 1) << (4*ch));
            return res;
        end
        return m_fg;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input int a, input int d);
        addr = 14'(a); wr_data = 32'(d); cs = 1'b1; write = 1'b1;
        tick();
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic tile_write(input int idx, input int hid, input int code);
        cpu_write(idx, (hid << 8) | code);
        m_hid[idx]  = (hid != 0);
        m_code[idx] = code;
    endtask

    task automatic reg_write(input int r, input int d);
        cpu_write(32'h2000 | r, d);
        if (r == 0) m_mode = d & 3;
        if (r == 1) m_fg = d & 'hFFF;
        if (r == 2 && !m_busy) begin
            m_busy = 1'b1; m_slot = d & 255; m_strobes = 0;
        end
    endtask

    // One frame strobe followed by a spare cycle so a pending clear can land.
    task automatic frame();
        x = 11'd1; y = 11'd0; tick();
        x = 11'd0; y = 11'd0; tick();
        x = 11'd1; y = 11'd0; tick();
        if (m_busy) begin
            m_strobes++;
            if (m_prog() == TILE) begin
                m_hid[m_slot] = 1'b0;
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic probe(input int px, input int py, input int si, input int ex, input string name);
        x = 11'(px); y = 11'(py); si_rgb = 12'(si);
        tick(); tick(); tick();
        chk(name, 32'(so_rgb), 32'(ex));
    endtask

    task automatic probe_m(input int px, input int py, input string name);
        int si;
        si = int'($urandom_range(0, 4095));
        probe(px, py, si, model_so(px, py, si), name);
    endtask

    // Back-to-back pixels, each output checked exactly three cycles later.
    task automatic stream(input int n, input bit bias);
        int expq[$];
        int px, py, s;
        for (int j = 0; j < n + 2; j++) begin
            if (j < n) begin
                if (bias && j[0]) begin
                    px = int'($urandom_range(1, 15)); py = int'($urandom_range(0, 15));
                end else begin
                    px = int'($urandom_range(0, 2047)); py = int'($urandom_range(0, 2047));
                end
                if (px == 0 && py == 0) px = 1;
                s = int'($urandom_range(0, 4095));
                expq.push_back(model_so(px, py, s));
                x = 11'(px); y = 11'(py); si_rgb = 12'(s);
            end
            tick();
            if (j >= 2) chk("stream", 32'(so_rgb), 32'(expq.pop_front()));
        end
    endtask

    typedef struct {
        bit cfg;
        int mode;
        int fg;
        int px;
        int py;
        int si;
        int ex;
    } vec_t;

    vec_t vt [17];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b0, 0, 'hFFF,  48,  32, 'h123, 'hFFF};
        vt[1]  = '{1'b0, 0, 'hFFF,  10,  10, 'h456, 'h456};
        vt[2]  = '{1'b1, 0, 'hF00,  48,  32, 'h123, 'hF00};
        vt[3]  = '{1'b1, 0, 'hF00,  63,  47, 'h123, 'hF00};
        vt[4]  = '{1'b1, 0, 'hF00,  47,  32, 'h123, 'h123};
        vt[5]  = '{1'b1, 0, 'hF00,  64,  40, 'hABC, 'hABC};
        vt[6]  = '{1'b1, 0, 'hF00,  48,  31, 'hABC, 'hABC};
        vt[7]  = '{1'b1, 0, 'hF00,  48,  48, 'h5A5, 'h5A5};
        vt[8]  = '{1'b1, 0, 'h0F0,  55,  33, 'h000, 'h0F0};
        vt[9]  = '{1'b1, 0, 'hF00, 560, 160, 'h000, 'hF00};
        vt[10] = '{1'b1, 2, 'hF00,  50,  40, 'h0F0, 'h770};
        vt[11] = '{1'b1, 2, 'hF00,  10,  10, 'h0F0, 'h0F0};
        vt[12] = '{1'b1, 2, 'hFFF,  50,  40, 'hFFF, 'hFFF};
        vt[13] = '{1'b1, 2, 'h135,  50,  40, 'h9BD, 'h579};
        vt[14] = '{1'b1, 1, 'hF00,  50,  40, 'h0F0, 'h0F0};
        vt[15] = '{1'b1, 1, 'hF00,  10,  10, 'h0F0, 'h0F0};
        vt[16] = '{1'b1, 3, 'hF00,  50,  40, 'h0F0, 'hF00};

        cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        x = 11'd1; y = 11'd0; si_rgb = 12'h3C3;
        m_mode = 0; m_fg = 'hFFF; m_busy = 1'b0; m_slot = 0; m_strobes = 0;

        // Reset state
        tick(); tick();
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_so_rgb", 32'(so_rgb), 32'h0);
        chk("reset_glyph_addr", 32'(glyph_addr), 32'h0);
        #2 reset_n = 1'b1;
        tick();

        // Software clears the map, then one card at tile (3,2)
        for (int i = 0; i < NCOL*NROW; i++) tile_write(i, 0, 0);
        tile_write(2*NCOL + 3, 0, 5);

        // Blend table
        for (int i = 0; i < 17; i++) begin
            if (vt[i].cfg) begin
                reg_write(0, vt[i].mode);
                reg_write(1, vt[i].fg);
            end
            probe(vt[i].px, vt[i].py, vt[i].si, vt[i].ex, $sformatf("table[%0d]", i));
        end

        // Flip slot 0 with a second hidden card next to it
        reg_write(0, 0);
        reg_write(1, 'hF00);
        tile_write(0, 1, 7);
        tile_write(1, 1, 7);
        reg_write(2, 0);
        chk("flip_start_busy", rd_data, 32'h8000_0000);
        for (int k = 1; k <= 16; k++) begin
            frame(); frame();
            if (k == 1 || k == 3 || k == 8) begin
                chk($sformatf("flip_progress_k%0d", k), rd_data, 32'h8000_0000 | 32'(k));
                probe(3, k - 1, 'h0A0, 'hF00, $sformatf("wipe_shown_k%0d", k));
                probe(3, k, 'h0A0, 'h0A0, $sformatf("wipe_back_k%0d", k));
            end
            if (k == 3) begin
                reg_write(2, 1);
                chk("second_start_ignored", rd_data, 32'h8000_0003);
                probe_m(19, 0, "other_slot_hidden");
            end
        end
        chk("flip_done_status", rd_data, 32'h0000_0010);
        probe(3, 0, 'h00F, 'hF00, "flip_done_row0");
        probe(3, 15, 'h00F, 'hF00, "flip_done_row15");
        probe(19, 5, 'h00F, 'h00F, "other_slot_still_hidden");

        // CPU write collides with the engine clear
        tile_write(5, 1, 9);
        reg_write(2, 5);
        for (int i = 0; i < 31; i++) frame();
        chk("collide_pre", rd_data, 32'h8000_000F);
        x = 11'd1; y = 11'd0; tick();
        x = 11'd0; y = 11'd0; tick();
        x = 11'd1; addr = 14'd5; wr_data = 32'h107; cs = 1'b1; write = 1'b1;
        tick();
        cs = 1'b0; write = 1'b0;
        chk("collide_retry_busy", rd_data, 32'h8000_0010);
        tick();
        chk("collide_cleared", rd_data, 32'h0000_0010);
        m_busy = 1'b0; m_code[5] = 7; m_hid[5] = 1'b0;
        probe(83, 4, 'h222, 'hF00, "collide_cpu_code_visible");
        probe_m(95, 15, "collide_corner");

        // Random maps and modes, engine idle
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NCOL*NROW; i++)
                tile_write(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
            reg_write(0, r);
            reg_write(1, int'($urandom_range(0, 4095)));
            stream(60, r[0]);
        end

        // Flip in progress, then abort by asynchronous reset at progress 5
        tile_write(0, 1, 7);
        reg_write(0, 0);
        reg_write(1, 'hF0F);
        reg_write(2, 0);
        for (int i = 0; i < 10; i++) frame();
        chk("abort_pre", rd_data, 32'h8000_0005);
        stream(80, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_rd_data", rd_data, 32'h0);
        chk("abort_so_rgb", 32'(so_rgb), 32'h0);
        m_mode = 0; m_fg = 'hFFF; m_busy = 1'b0; m_strobes = 0;
        #2 reset_n = 1'b1;
        tick();
        probe(3, 0, 'h321, 'h321, "abort_still_hidden");
        reg_write(2, 0);
        chk("restart_progress0", rd_data, 32'h8000_0000);
        frame(); frame();
        chk("restart_progress1", rd_data, 32'h8000_0001);
        probe(3, 0, 'h321, 'hFFF, "restart_row0_shown");
        probe_m(3, 1, "restart_row1_back");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
